// File: rtl/greycode_pkg.sv
// ============================================================================
// Module      : greycode_pkg
// Description : Shared Gray-code helpers and buffer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package greycode_pkg;

  // Helpers operate on a fixed maximum width; callers size-cast in and out.
  localparam int c_MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  function automatic logic [c_MAX_WIDTH-1:0] bin2gray(input logic [c_MAX_WIDTH-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [6:0] popcount(input logic [c_MAX_WIDTH-1:0] value);
    logic [6:0] count;
    count = '0;
    for (int i = 0; i < c_MAX_WIDTH; i++) begin
      count = count + 7'(value[i]);
    end
    return count;
  endfunction

endpackage : greycode_pkg

`default_nettype wire

// File: rtl/greycode_skid_buf.sv
// ============================================================================
// Module      : greycode_skid_buf
// Description : Data-agnostic 2-entry skid buffer; in_ready is registered.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module greycode_skid_buf
  import greycode_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  state_t           r_state;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic             r_out_valid;
  logic             r_in_ready;

  logic w_in_xfer;
  logic w_out_xfer;

  assign w_in_xfer  = in_valid && r_in_ready;
  assign w_out_xfer = r_out_valid && out_ready;

  // in_ready mirrors "skid slot empty" so no combinational path from out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= EMPTY;
      r_main      <= '0;
      r_skid      <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_xfer) begin
            r_main      <= in_data;
            r_out_valid <= 1'b1;
            r_state     <= ONE;
          end
        end
        ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            r_main <= in_data;
          end else if (w_in_xfer) begin
            r_skid     <= in_data;
            r_in_ready <= 1'b0;
            r_state    <= FULL;
          end else if (w_out_xfer) begin
            r_out_valid <= 1'b0;
            r_state     <= EMPTY;
          end
        end
        FULL: begin
          if (w_out_xfer) begin
            r_main     <= r_skid;
            r_in_ready <= 1'b1;
            r_state    <= ONE;
          end
        end
        default: begin
          r_state     <= EMPTY;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_main;

endmodule : greycode_skid_buf

`default_nettype wire

// File: rtl/greycode_encoder.sv
// ============================================================================
// Module      : greycode_encoder
// Description : Streaming binary-to-Gray encoder with skid-buffered output.
//               Optional adjacency check enabled by GREYCODE_ENC_ADJ_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module greycode_encoder
  import greycode_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [CNT_WIDTH-1:0] out_cnt,
  output logic                 out_adj_err
);

  localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = CNT_WIDTH'(1);

  generate
    if (WIDTH < 2 || WIDTH > c_MAX_WIDTH) begin : g_bad_width
      $error("greycode_encoder: WIDTH out of range");
    end
  endgenerate

  logic [WIDTH-1:0]     w_enc;
  logic                 w_out_xfer;
  logic [CNT_WIDTH-1:0] r_out_cnt;

  // Zero-extension keeps the MSB a pass-through after the shift.
  assign w_enc = WIDTH'(bin2gray(c_MAX_WIDTH'(in_data)));

  greycode_skid_buf #(
    .WIDTH (WIDTH)
  ) u_skid_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (w_enc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  assign w_out_xfer = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_cnt <= '0;
    end else if (w_out_xfer) begin
      r_out_cnt <= r_out_cnt + c_CNT_ONE;
    end
  end

  assign out_cnt = r_out_cnt;

`ifdef GREYCODE_ENC_ADJ_CHECK_EN
  logic [WIDTH-1:0] r_last_gray;
  logic             r_has_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_gray <= '0;
      r_has_last  <= 1'b0;
    end else if (w_out_xfer) begin
      r_last_gray <= out_data;
      r_has_last  <= 1'b1;
    end
  end

  // Consecutive Gray words must differ in exactly one bit.
  assign out_adj_err = out_valid && r_has_last &&
                       (popcount(c_MAX_WIDTH'(out_data ^ r_last_gray)) != 7'd1);
`else
  assign out_adj_err = 1'b0;
`endif

endmodule : greycode_encoder

`default_nettype wire

// File: tb/tb_greycode_encoder.sv
// ============================================================================
// Module      : tb_greycode_encoder
// Description : Randomized and directed bench against a FIFO-occupancy model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_greycode_encoder;

  localparam int WIDTH     = 8;
  localparam int CNT_WIDTH = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [WIDTH-1:0]     out_data;
  logic [CNT_WIDTH-1:0] out_cnt;
  logic                 out_adj_err;

  greycode_encoder #(
    .WIDTH     (WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_cnt     (out_cnt),
    .out_adj_err (out_adj_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference: a 2-deep FIFO of Gray words, a transfer counter, last word sent.
  logic [WIDTH-1:0] ref_q[$];
  int unsigned      ref_cnt = 0;
  bit               ref_has_last = 1'b0;
  logic [WIDTH-1:0] ref_last = '0;

  function automatic logic [WIDTH-1:0] ref_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    bit exp_adj;
    check("out_valid", 32'(out_valid), 32'(ref_q.size() > 0));
    check("in_ready", 32'(in_ready), 32'(ref_q.size() < 2));
    check("out_cnt", 32'(out_cnt), 32'(ref_cnt % (1 << CNT_WIDTH)));
    exp_adj = 1'b0;
    if (ref_q.size() > 0) begin
      check("out_data", 32'(out_data), 32'(ref_q[0]));
`ifdef GREYCODE_ENC_ADJ_CHECK_EN
      exp_adj = ref_has_last && ($countones(ref_q[0] ^ ref_last) != 1);
`endif
      check("adj_err", 32'(out_adj_err), 32'(exp_adj));
    end
`ifndef GREYCODE_ENC_ADJ_CHECK_EN
    else begin
      check("adj_err_off", 32'(out_adj_err), 32'(exp_adj));
    end
`endif
  endtask

  task automatic tick(input bit v, input logic [WIDTH-1:0] d, input bit r);
    bit in_x;
    bit out_x;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    in_x  = v && (ref_q.size() < 2);
    out_x = r && (ref_q.size() > 0);
    @(posedge clk);
    if (out_x) begin
      ref_last     = ref_q.pop_front();
      ref_has_last = 1'b1;
      ref_cnt++;
    end
    if (in_x) ref_q.push_back(ref_gray(d));
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) tick(1'b0, WIDTH'($urandom), 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p;
    int cyc;

    // Reset state
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_cnt", 32'(out_cnt), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_adj_err", 32'(out_adj_err), 32'd0);
    rst_n = 1'b1;

    // Sweep 0..255 back to back
    for (int i = 0; i < 256; i++) tick(1'b1, WIDTH'(i), 1'b1);
    check("sweep_last", 32'(out_data), 32'h80);
    drain();

    // Backpressure: stall output three cycles mid-stream
    p = 0;
    cyc = 0;
    while (p < 8 && cyc < 50) begin
      bit acc;
      acc = (ref_q.size() < 2);
      tick(1'b1, WIDTH'(8'h10 + p), !(cyc >= 3 && cyc <= 5));
      if (acc) p++;
      cyc++;
    end
    check("bp_all_sent", 32'(p), 32'd8);
    drain();

    // Simultaneous input/output in ONE state
    tick(1'b1, 8'h30, 1'b0);
    tick(1'b1, 8'h40, 1'b1);
    check("simul_data", 32'(out_data), 32'h60);
    check("simul_ready", 32'(in_ready), 32'd1);
    drain();

    // Adjacency pairs
    tick(1'b1, 8'h05, 1'b1);
    tick(1'b1, 8'h07, 1'b1);
    tick(1'b1, 8'h05, 1'b1);
    tick(1'b1, 8'h06, 1'b1);
    drain();

    // Reset while FULL
    tick(1'b1, 8'h05, 1'b0);
    tick(1'b1, 8'h06, 1'b0);
    check("full_in_ready", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_out_cnt", 32'(out_cnt), 32'd0);
    ref_q.delete();
    ref_cnt      = 0;
    ref_has_last = 1'b0;
    #1 rst_n = 1'b1;
    tick(1'b1, 8'h03, 1'b1);
    check("post_rst_data", 32'(out_data), 32'h02);
    tick(1'b0, 8'h00, 1'b1);
    check("post_rst_cnt", 32'(out_cnt), 32'd1);

    // Counter wrap: 17 transfers more
    for (int i = 0; i < 17; i++) tick(1'b1, WIDTH'($urandom), 1'b1);
    drain();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom_range(0, 3) != 0), WIDTH'($urandom), ($urandom_range(0, 2) != 0));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_greycode_encoder

`default_nettype wire
